lcd_host_seq: RTL and testbench

Command-side initiator for the LCD image controller. It fetches 4-bit commands from a command memory and issues each one over the `cmd`/`cmd_valid`/`busy` handshake. When the final write command is issued, it monitors the controller's IRAM write-back stream, counts and checksums the written pixels, and signals completion. It sits between the testbench or system command source and the LCD controller, driving the controller's command inputs and observing its IRAM outputs.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_host_seq_if.sv | 16 +
 rtl/lcd_wb_monitor.sv | 60 ++++++
 rtl/lcd_host_seq.sv | 128 ++++++++++++
 tb/tb_lcd_host_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host sequencer: command codes, host FSM states
// and the default number of write-back pixels.
package lcd_pkg;

    localparam logic [3:0] WR    = 4'h0;
    localparam logic [3:0] UP    = 4'h1;
    localparam logic [3:0] DOWN  = 4'h2;
    localparam logic [3:0] LEFT  = 4'h3;
    localparam logic [3:0] RIGHT = 4'h4;
    localparam logic [3:0] MAX   = 4'h5;
    localparam logic [3:0] MIN   = 4'h6;
    localparam logic [3:0] AVG   = 4'h7;
    localparam logic [3:0] CCWR  = 4'h8;
    localparam logic [3:0] CWR   = 4'h9;
    localparam logic [3:0] MX    = 4'hA;
    localparam logic [3:0] MY    = 4'hB;

    localparam int PIX_N_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_WAIT, S_ISSUE, S_GUARD, S_CMD_WAIT, S_WRITEOUT, S_FINISH
    } host_state_e;

    function automatic logic cmd_legal(input logic [3:0] c);
        return c <= MY;
    endfunction

endpackage

// File: rtl/lcd_host_seq_if.sv
// Command handshake and IRAM write-back observation bundle between the host
// sequencer (master) and the LCD controller (slave).
interface lcd_host_seq_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;

    modport master (output cmd, cmd_valid,
                    input  busy, done, IRAM_valid, IRAM_A, IRAM_D);
    modport slave  (input  cmd, cmd_valid,
                    output busy, done, IRAM_valid, IRAM_A, IRAM_D);
endinterface

// File: rtl/lcd_wb_monitor.sv
// IRAM write-back monitor: saturating pixel counter, address-order check and,
// when LCD_HOST_CHECKSUM_EN is defined, a modulo-2^16 data checksum.
module lcd_wb_monitor (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        valid_i,
    input  logic [5:0]  addr_i,
    input  logic [7:0]  data_i,
    output logic [6:0]  pix_cnt_o,
    output logic [6:0]  cnt_next_o,
    output logic [15:0] checksum_o,
    output logic        addr_err_o
);
    logic [6:0] cnt_q, cnt_d;
    logic       wr;

    assign wr = en_i && valid_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (wr && cnt_q != 7'd127)
            cnt_d = cnt_q + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Pixel k is expected at address k, so compare against the pre-increment count.
    assign addr_err_o = wr && (addr_i != cnt_q[5:0]);
    assign pix_cnt_o  = cnt_q;
    assign cnt_next_o = cnt_d;

`ifdef LCD_HOST_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i)   sum_d = '0;
        else if (wr) sum_d = sum_q + {8'd0, data_i};
    end

    always_ff @(posedge clk) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign checksum_o = sum_q;
`else
    logic unused_data;
    assign unused_data = ^data_i;
    assign checksum_o  = '0;
`endif

endmodule

// File: rtl/lcd_host_seq.sv
// LCD host sequencer: fetches commands from a command memory, issues them over
// the cmd/busy handshake, then checks the IRAM write-back (LCD_HOST_CHECKSUM_EN).
module lcd_host_seq
    import lcd_pkg::*;
#(
    parameter int CMD_AW = 5,
    parameter int PIX_N  = PIX_N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [CMD_AW-1:0] cmd_rom_addr,
    input  logic [3:0]        cmd_rom_q,
    lcd_host_seq_if.master    ctl,
    output logic              finished,
    output logic              err,
    output logic [6:0]        pix_cnt,
    output logic [15:0]       checksum
);
    host_state_e       state_q, state_d;
    logic [CMD_AW-1:0] addr_q, addr_d;
    logic [3:0]        cmd_q, cmd_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic              fin_q, fin_d;
    logic              wrap_q, wrap_d;
    logic              clr;
    logic              addr_err;
    logic [6:0]        cnt_next;

    lcd_wb_monitor u_mon (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clr),
        .en_i       (state_q == S_WRITEOUT),
        .valid_i    (ctl.IRAM_valid),
        .addr_i     (ctl.IRAM_A),
        .data_i     (ctl.IRAM_D),
        .pix_cnt_o  (pix_cnt),
        .cnt_next_o (cnt_next),
        .checksum_o (checksum),
        .addr_err_o (addr_err)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        fin_d   = fin_q;
        wrap_d  = wrap_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = '0;
                err_d   = 1'b0;
                fin_d   = 1'b0;
                wrap_d  = 1'b0;
                clr     = 1'b1;
                state_d = S_INIT_WAIT;
            end
            // Command is latched here so cmd/cmd_valid are registered in ISSUE.
            S_INIT_WAIT, S_CMD_WAIT: if (!ctl.busy) begin
                vld_d   = 1'b1;
                state_d = S_ISSUE;
                if (wrap_q) begin
                    cmd_d = WR;
                end else if (!cmd_legal(cmd_rom_q)) begin
                    cmd_d = WR;
                    err_d = 1'b1;
                end else begin
                    cmd_d = cmd_rom_q;
                end
            end
            S_ISSUE: begin
                if (cmd_q == WR) begin
                    state_d = S_WRITEOUT;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_GUARD;
                    if (addr_q == '1) begin
                        wrap_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_GUARD: state_d = S_CMD_WAIT;
            S_WRITEOUT: begin
                if (addr_err) err_d = 1'b1;
                if (ctl.done) begin
                    fin_d   = 1'b1;
                    state_d = S_FINISH;
                    if (cnt_next != 7'(PIX_N)) err_d = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cmd_q   <= WR;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cmd_rom_addr  = addr_q;
    assign ctl.cmd       = cmd_q;
    assign ctl.cmd_valid = vld_q;
    assign err           = err_q;
    assign finished      = fin_q;

endmodule

// File: tb/tb_lcd_host_seq.sv
// Self-checking bench for lcd_host_seq: controller stub with a command
// scoreboard, scripted IRAM write-back streams and reset/abort scenarios.
module tb_lcd_host_seq;
    import lcd_pkg::*;

    localparam int CMD_AW = 5;
`ifdef LCD_HOST_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CMD_AW-1:0] cmd_rom_addr;
    logic [3:0]        cmd_rom_q;
    logic              finished, err;
    logic [6:0]        pix_cnt;
    logic [15:0]       checksum;
    logic [3:0]        rom [32];

    int  vectors = 0, miscompares = 0, cyc = 0, issued = 0, last_issue = -100, busy_cnt = 0;
    int  hold = 1;
    bit  stuck = 1'b0;
    logic [3:0] exp_q [$];

    lcd_host_seq_if ctl ();

    lcd_host_seq #(.CMD_AW(CMD_AW), .PIX_N(64)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_rom_addr(cmd_rom_addr), .cmd_rom_q(cmd_rom_q), .ctl(ctl),
        .finished(finished), .err(err), .pix_cnt(pix_cnt), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign cmd_rom_q = rom[cmd_rom_addr];

    function automatic logic [15:0] exp_sum(input int n, input logic [7:0] d);
        return CK_EN ? 16'(n * int'(d)) : 16'd0;
    endfunction

    // Controller stub: goes busy on each command, releases after `hold` cycles.
    always @(negedge clk) begin
        logic [3:0] e;
        if (reset) begin
            ctl.busy = 1'b0; busy_cnt = 0; last_issue = -100; exp_q.delete();
        end else if (ctl.cmd_valid) begin
            vectors++;
            if (ctl.busy !== 1'b0) begin
                miscompares++; $display("FAIL valid_while_busy: busy=%b required 0", ctl.busy);
            end
            vectors++;
            if (cyc - last_issue < 3) begin
                miscompares++; $display("FAIL cmd_spacing: gap=%0d required >=3", cyc - last_issue);
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL unexpected_cmd: cmd=%h required none", ctl.cmd);
            end else begin
                e = exp_q.pop_front();
                if (ctl.cmd !== e) begin
                    miscompares++; $display("FAIL cmd_value: cmd=%h required %h", ctl.cmd, e);
                end
            end
            issued++; last_issue = cyc; ctl.busy = 1'b1; busy_cnt = hold;
        end else if (ctl.busy && !stuck) begin
            if (busy_cnt > 1) busy_cnt--;
            else begin busy_cnt = 0; ctl.busy = 1'b0; end
        end
    end

    task automatic apply_reset;
        reset = 1'b1; start = 1'b0; ctl.done = 1'b0;
        ctl.IRAM_valid = 1'b0; ctl.IRAM_A = '0; ctl.IRAM_D = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_rom(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        for (int i = 0; i < 32; i++) rom[i] = WR;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_wr_issue;
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (ctl.cmd_valid === 1'b1 && ctl.cmd === WR) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wr_issue_timeout: seen=0 required 1"); end
    endtask

    // Drives n writes; position dup_pos repeats the previous address. Returns
    // at the first negedge after done was sampled.
    task automatic writeout(input int n, input logic [7:0] d, input int dup_pos, output logic fin_before);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ctl.IRAM_valid = 1'b1; ctl.IRAM_D = d;
            ctl.IRAM_A = (i == dup_pos) ? 6'(i - 1) : 6'(i);
        end
        @(negedge clk);
        ctl.IRAM_valid = 1'b0; ctl.done = 1'b1; fin_before = finished;
        @(negedge clk);
        ctl.done = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        vectors++; if (ctl.cmd !== 4'h0) begin miscompares++; $display("FAIL rst_cmd: got %h required 0", ctl.cmd); end
        vectors++; if (ctl.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid: got %b required 0", ctl.cmd_valid); end
        vectors++; if (cmd_rom_addr !== '0) begin miscompares++; $display("FAIL rst_addr: got %0d required 0", cmd_rom_addr); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL rst_finished: got %b required 0", finished); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b required 0", err); end
        vectors++; if (pix_cnt !== 7'd0) begin miscompares++; $display("FAIL rst_pix_cnt: got %0d required 0", pix_cnt); end
        vectors++; if (checksum !== 16'd0) begin miscompares++; $display("FAIL rst_checksum: got %h required 0", checksum); end
    endtask

    task automatic test_cmd_seq;
        logic fb;
        apply_reset(); load_rom(RIGHT, DOWN, MAX, WR);
        exp_q.push_back(RIGHT); exp_q.push_back(DOWN); exp_q.push_back(MAX); exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        writeout(64, 8'hFF, -1, fb);
        vectors++; if (fb !== 1'b0) begin miscompares++; $display("FAIL seq_fin_early: got %b required 0", fb); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL seq_finished: got %b required 1", finished); end
        vectors++; if (pix_cnt !== 7'd64) begin miscompares++; $display("FAIL seq_pix_cnt: got %0d required 64", pix_cnt); end
        vectors++; if (checksum !== exp_sum(64, 8'hFF)) begin miscompares++; $display("FAIL seq_checksum: got %h required %h", checksum, exp_sum(64, 8'hFF)); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL seq_err: got %b required 0", err); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL seq_pending: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_illegal;
        logic fb;
        apply_reset(); load_rom(4'hE, UP, UP, WR);
        exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b required 1", err); end
        writeout(64, 8'h01, -1, fb);
        vectors++; if (finished !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL illegal_end: fin=%b err=%b required 1 1", finished, err); end
    endtask

    task automatic test_addr_dup;
        logic fb;
        apply_reset(); load_rom(WR, WR, WR, WR);
        exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        writeout(64, 8'h11, 6, fb);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL dup_err: got %b required 1", err); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL dup_finished: got %b required 1", finished); end
        vectors++; if (pix_cnt !== 7'd64) begin miscompares++; $display("FAIL dup_pix_cnt: got %0d required 64", pix_cnt); end
    endtask

    task automatic test_short_count;
        logic fb;
        apply_reset(); load_rom(WR, WR, WR, WR);
        exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        writeout(10, 8'h80, -1, fb);
        vectors++; if (pix_cnt !== 7'd10) begin miscompares++; $display("FAIL short_pix_cnt: got %0d required 10", pix_cnt); end
        vectors++; if (checksum !== exp_sum(10, 8'h80)) begin miscompares++; $display("FAIL short_checksum: got %h required %h", checksum, exp_sum(10, 8'h80)); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL short_err: got %b required 1", err); end
    endtask

    task automatic test_stall;
        int base;
        apply_reset(); load_rom(LEFT, UP, WR, WR);
        exp_q.push_back(LEFT);
        stuck = 1'b1; base = issued;
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (20) @(negedge clk);
        vectors++; if (issued - base != 1) begin miscompares++; $display("FAIL stall_issues: got %0d required 1", issued - base); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL stall_finished: got %b required 0", finished); end
        vectors++; if (cmd_rom_addr !== 5'd1) begin miscompares++; $display("FAIL stall_addr: got %0d required 1", cmd_rom_addr); end
        stuck = 1'b0;
        apply_reset();
    endtask

    task automatic test_reset_mid;
        logic fb;
        apply_reset(); load_rom(WR, WR, WR, WR);
        exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ctl.IRAM_valid = 1'b1; ctl.IRAM_D = 8'h5A; ctl.IRAM_A = (i == 3) ? 6'd2 : 6'(i);
        end
        @(negedge clk); ctl.IRAM_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (pix_cnt !== 0 || checksum !== 0 || err !== 0 || finished !== 0 || ctl.cmd_valid !== 0 || cmd_rom_addr !== 0) begin
            miscompares++;
            $display("FAIL mid_reset: cnt=%0d sum=%h err=%b fin=%b vld=%b addr=%0d required all 0",
                     pix_cnt, checksum, err, finished, ctl.cmd_valid, cmd_rom_addr);
        end
        reset = 1'b0;
        load_rom(MIN, WR, WR, WR);
        @(negedge clk);
        exp_q.push_back(MIN); exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        vectors++; if (cmd_rom_addr !== 5'd1) begin miscompares++; $display("FAIL restart_addr: got %0d required 1", cmd_rom_addr); end
        writeout(64, 8'h02, -1, fb);
        vectors++; if (finished !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL restart_end: fin=%b err=%b required 1 0", finished, err); end
    endtask

    task automatic test_wrap;
        logic fb;
        apply_reset();
        for (int i = 0; i < 32; i++) rom[i] = UP;
        for (int i = 0; i < 32; i++) exp_q.push_back(UP);
        exp_q.push_back(WR);
        pulse_start(); wait_wr_issue();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wrap_err: got %b required 1", err); end
        vectors++; if (cmd_rom_addr !== 5'd0) begin miscompares++; $display("FAIL wrap_addr: got %0d required 0", cmd_rom_addr); end
        writeout(64, 8'h03, -1, fb);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL wrap_finished: got %b required 1", finished); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_pending: got %0d required 0", exp_q.size()); end
    endtask

    initial begin
        ctl.busy = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = WR;
        test_reset();
        test_cmd_seq();
        test_illegal();
        test_addr_dup();
        test_short_count();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
